// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the ID->EX issue controller.
//   state_t       controller FSM states
//   NREG          default number of tracked architectural registers
//   MAX_INFLIGHT  default limit on issued-but-not-written-back writers
//   REG_W         width of a register index field
//   CNT_W         width of each per-register pending-write counter
package pipe_ctrl_pkg;

  localparam int NREG         = 32;
  localparam int MAX_INFLIGHT = 3;
  localparam int REG_W        = 5;
  localparam int CNT_W        = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters and the RAW hazard lookup
// for the instruction sitting in decode.
//   clk, rst          clock and synchronous active-high reset
//   inc_en, inc_rd    a writer to inc_rd is issued this cycle
//   dec_en, dec_rd    a writeback to dec_rd happens this cycle
//   rs1/rs2/rd        decode register fields; use_* say which ones are read
//   busy              one bit per register, set while its counter is non-zero
//   hazard            some used source still has a pending write
//   spurious          this cycle's writeback targets a register with nothing pending
module reg_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG = pipe_ctrl_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [REG_W-1:0] inc_rd,
  input  logic             dec_en,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             use_rd,
  output logic [NREG-1:0]  busy,
  output logic             hazard,
  output logic             spurious
);

  // All counters flattened so the decode lookups can use a variable part-select.
  logic [NREG*CNT_W-1:0] cnt_flat;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [CNT_W-1:0] cnt_reg;
      logic             inc_hit;
      logic             dec_hit;

      assign inc_hit = inc_en && (inc_rd == REG_W'(gi));
      assign dec_hit = dec_en && (dec_rd == REG_W'(gi));

      // An issue and a writeback on the same register cancel out.
      // A writeback with nothing pending leaves the counter at zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (inc_hit && !dec_hit) begin
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (dec_hit && !inc_hit) begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      assign busy[gi] = (cnt_reg != '0);
    end
  endgenerate

  // A source is blocked by a pending write unless that write is the last one
  // outstanding and it lands this very cycle (write-through).
  function automatic logic src_blocked(
    input logic             used,
    input logic [CNT_W-1:0] cnt,
    input logic [REG_W-1:0] idx,
    input logic             wb_en,
    input logic [REG_W-1:0] wb_idx
  );
    logic through;
    through = (cnt == CNT_W'(1)) && wb_en && (wb_idx == idx);
    return used && (cnt != '0) && !through;
  endfunction

  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_wb;

  always_comb begin
    cnt_rs1  = cnt_flat[rs1*CNT_W +: CNT_W];
    cnt_rs2  = cnt_flat[rs2*CNT_W +: CNT_W];
    cnt_rd   = cnt_flat[rd*CNT_W +: CNT_W];
    cnt_wb   = cnt_flat[dec_rd*CNT_W +: CNT_W];
    hazard   = src_blocked(use_rs1, cnt_rs1, rs1, dec_en, dec_rd)
             | src_blocked(use_rs2, cnt_rs2, rs2, dec_en, dec_rd)
             | src_blocked(use_rd,  cnt_rd,  rd,  dec_en, dec_rd);
    spurious = dec_en && (cnt_wb == '0);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decides each cycle whether the decode instruction moves to EX,
// tracks in-flight writers, and sequences halt drain / resume.
//   clk, rst                 clock and synchronous active-high reset
//   id_valid, id_halt        decode holds a (halt) instruction
//   id_rd/rs1/rs2            decode register fields
//   id_uses_rs1/rs2/rd       which fields are read as sources
//   id_writes_rd             the instruction will write back rd
//   ex_ready                 execute can accept this cycle
//   wb_valid, wb_rd          writeback this cycle
//   flush                    kill the decode instruction (branch redirect)
//   resume                   leave HALTED
//   issue, stall             combinational ID->EX move / IF-ID hold
//   busy                     per-register pending-write flags
//   inflight                 number of in-flight writers
//   halted                   controller is in HALTED
//   wb_err                   sticky flag: writeback with nothing pending
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG         = pipe_ctrl_pkg::NREG,
  parameter int MAX_INFLIGHT = pipe_ctrl_pkg::MAX_INFLIGHT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_uses_rd,
  input  logic            id_writes_rd,
  input  logic            id_halt,
  input  logic            ex_ready,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  input  logic            resume,
  output logic            issue,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic [1:0]      inflight,
  output logic            halted,
  output logic            wb_err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

  state_t     state_reg;
  logic       halted_reg;
  logic [1:0] inflight_reg;
  logic       wb_err_reg;

  logic hazard;
  logic spurious;
  logic accept_state;
  logic can_take;
  logic writer_issue;
  logic retire;

  reg_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (writer_issue),
    .inc_rd   (id_rd),
    .dec_en   (wb_valid),
    .dec_rd   (wb_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rd       (id_rd),
    .use_rs1  (id_uses_rs1),
    .use_rs2  (id_uses_rs2),
    .use_rd   (id_uses_rd),
    .busy     (busy),
    .hazard   (hazard),
    .spurious (spurious)
  );

  assign accept_state = (state_reg == ST_RUN) || (state_reg == ST_STALL);
  // A writeback this cycle frees a slot, so a full window can still take one.
  assign can_take     = (inflight_reg < MAX_CNT) || wb_valid;
  assign issue        = !rst && id_valid && !flush && !id_halt && !hazard
                      && ex_ready && can_take && accept_state;
  assign stall        = (id_valid && !flush && !issue) || !accept_state;
  assign writer_issue = issue && id_writes_rd;
  assign retire       = wb_valid && (inflight_reg != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (id_valid && !flush && id_halt)
            state_reg <= ST_DRAIN;
          else if (id_valid && !flush && !issue)
            state_reg <= ST_STALL;
        end
        ST_STALL: begin
          if (id_valid && !flush && id_halt)
            state_reg <= ST_DRAIN;
          else if (issue || flush)
            state_reg <= ST_RUN;
        end
        ST_DRAIN: begin
          // Wait until the last writer has left and nothing lands this cycle.
          if (inflight_reg == 2'd0 && !wb_valid) begin
            state_reg  <= ST_HALTED;
            halted_reg <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= 2'd0;
    end else begin
      case ({writer_issue, retire})
        2'b10: if (inflight_reg != MAX_CNT) inflight_reg <= inflight_reg + 2'd1;
        2'b01: inflight_reg <= inflight_reg - 2'd1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wb_err_reg <= 1'b0;
    else if (spurious)
      wb_err_reg <= 1'b1;
  end

  assign inflight = inflight_reg;
  assign halted   = halted_reg;
  assign wb_err   = wb_err_reg;

endmodule
